// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding and
// default frame geometry.
package fifo_uart_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running bit-period counter. tick marks the last clock of each bit
// period; clear holds the count at zero so a new bit starts aligned.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;

    // Count 0..CLKS_PER_BIT-1 and wrap; clear forces the count back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = (cnt_r == LAST_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops one word per frame and serializes it
// LSB-first as start / data / optional even parity / stop bits on tx.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    // Bit counter must reach DATA_WIDTH-1 (data) and STOP_BITS-1 (stop).
    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
        return ^word;
    endfunction

    state_t                state_r;
    state_t                state_s;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [BCW-1:0]        bit_cnt_r;
    logic                  parity_r;
    logic                  tx_r;
    logic                  tick_s;
    logic                  clear_s;
    logic                  pop_s;
    logic                  frame_done_s;
    logic                  start_ok_s;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Next-state decode plus the pop request, baud clear and frame_done pulse.
    always_comb begin
        state_s      = state_r;
        pop_s        = 1'b0;
        clear_s      = 1'b0;
        frame_done_s = 1'b0;
        start_ok_s   = tx_en & ~fifo_empty;
        case (state_r)
            ST_IDLE: begin
                clear_s = 1'b1;
                if (start_ok_s) begin
                    pop_s   = 1'b1;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                clear_s = 1'b1;
                state_s = ST_START;
            end
            ST_START: begin
                if (tick_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s && (bit_cnt_r == LAST_DATA)) begin
                    state_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_s && (bit_cnt_r == LAST_STOP)) begin
                    frame_done_s = 1'b1;
                    // Chain straight into the next frame when more data waits.
                    if (start_ok_s) begin
                        pop_s   = 1'b1;
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Shift register, bit counter, latched parity and the registered line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r   <= '0;
            bit_cnt_r <= '0;
            parity_r  <= 1'b0;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= '0;
                    tx_r      <= 1'b1;
                end
                ST_FETCH: begin
                    shift_r   <= fifo_dout;
                    parity_r  <= even_parity(fifo_dout);
                    bit_cnt_r <= '0;
                    tx_r      <= 1'b0;
                end
                ST_START: begin
                    if (tick_s) begin
                        tx_r    <= shift_r[0];
                        shift_r <= shift_r >> 1;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (bit_cnt_r == LAST_DATA) begin
                            bit_cnt_r <= '0;
                            tx_r      <= (PARITY_EN != 0) ? parity_r : 1'b1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BCW'(1);
                            tx_r      <= shift_r[0];
                            shift_r   <= shift_r >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick_s) begin
                        tx_r <= 1'b1;
                    end
                end
                ST_STOP: begin
                    tx_r <= 1'b1;
                    if (tick_s) begin
                        if (bit_cnt_r == LAST_STOP) begin
                            bit_cnt_r <= '0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BCW'(1);
                        end
                    end
                end
                default: begin
                    tx_r <= 1'b1;
                end
            endcase
        end
    end

    // Pop and busy are gated by rst_n so both read low while reset is held.
    assign fifo_rd_en = rst_n & pop_s;
    assign busy       = rst_n & ((state_r != ST_IDLE) | pop_s);
    assign frame_done = frame_done_s;
    assign tx         = tx_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx. Three instances cover the parameter sets:
// 0: CLKS_PER_BIT=4, no parity, 1 stop; 1: CLKS_PER_BIT=4, parity, 1 stop;
// 2: CLKS_PER_BIT=2, no parity, 2 stops. Each has a small FIFO model.
module tb_fifo_uart_tx;

    logic       clk;
    logic       rst_n;
    logic [2:0] tx_en_v;
    logic [2:0] empty_v;
    logic [7:0] dout_a [3];
    logic [2:0] rd_v;
    logic [2:0] tx_v;
    logic [2:0] busy_v;
    logic [2:0] fd_v;

    logic [7:0] mem [3][8];
    int         wc [3];
    int         rp [3];

    int n_checks;
    int n_pass;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en_v[0]), .fifo_empty(empty_v[0]),
        .fifo_dout(dout_a[0]), .fifo_rd_en(rd_v[0]), .tx(tx_v[0]),
        .busy(busy_v[0]), .frame_done(fd_v[0]));

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en_v[1]), .fifo_empty(empty_v[1]),
        .fifo_dout(dout_a[1]), .fifo_rd_en(rd_v[1]), .tx(tx_v[1]),
        .busy(busy_v[1]), .frame_done(fd_v[1]));

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(2), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en_v[2]), .fifo_empty(empty_v[2]),
        .fifo_dout(dout_a[2]), .fifo_rd_en(rd_v[2]), .tx(tx_v[2]),
        .busy(busy_v[2]), .frame_done(fd_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign empty_v[0] = (rp[0] == wc[0]);
    assign empty_v[1] = (rp[1] == wc[1]);
    assign empty_v[2] = (rp[2] == wc[2]);

    // FIFO models: a sampled pop presents the head word on the next cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_v[i]) begin
                dout_a[i] <= mem[i][rp[i]];
                rp[i]     <= rp[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] w);
        mem[i][wc[i]] = w;
        wc[i]         = wc[i] + 1;
    endtask

    // Called on the negedge where a pop is expected: checks the pop cycle and
    // the FETCH cycle, returns on the first negedge of the start bit.
    task automatic start_frame(input int i);
        #1;
        check("pop_rd_en", 32'(rd_v[i]), 32'd1);
        check("pop_busy", 32'(busy_v[i]), 32'd1);
        check("pop_tx", 32'(tx_v[i]), 32'd1);
        @(negedge clk);
        check("fetch_rd_en", 32'(rd_v[i]), 32'd0);
        check("fetch_busy", 32'(busy_v[i]), 32'd1);
        check("fetch_tx", 32'(tx_v[i]), 32'd1);
        @(negedge clk);
    endtask

    // Checks every cycle of one frame from the first start-bit cycle.
    task automatic check_frame(input int i, input logic [7:0] w, input int cpb,
                               input int par, input int stops, input bit nxt,
                               input int drop_at);
        int   nbits;
        int   last;
        int   b;
        logic eb;
        nbits = 1 + 8 + par + stops;
        last  = nbits * cpb - 1;
        for (int k = 0; k <= last; k++) begin
            b = k / cpb;
            if (b == 0)                      eb = 1'b0;
            else if (b <= 8)                 eb = w[b-1];
            else if ((par != 0) && (b == 9)) eb = ^w;
            else                             eb = 1'b1;
            check("frame_tx", 32'(tx_v[i]), 32'(eb));
            check("frame_done", 32'(fd_v[i]), 32'(k == last));
            check("frame_busy", 32'(busy_v[i]), 32'd1);
            check("frame_rd_en", 32'(rd_v[i]), 32'(nxt && (k == last)));
            if (k == drop_at) tx_en_v[i] = 1'b0;
            if (k != last) @(negedge clk);
        end
        @(negedge clk);
        if (nxt) begin
            check("gap_tx", 32'(tx_v[i]), 32'd1);
            check("gap_busy", 32'(busy_v[i]), 32'd1);
            check("gap_rd_en", 32'(rd_v[i]), 32'd0);
            @(negedge clk);
        end else begin
            check("after_tx", 32'(tx_v[i]), 32'd1);
            check("after_busy", 32'(busy_v[i]), 32'd0);
            check("after_done", 32'(fd_v[i]), 32'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 3; i++) begin
            wc[i] = 0;
            rp[i] = 0;
        end
        rst_n   = 1'b0;
        tx_en_v = 3'b111;

        // Reset values with tx_en high and empty FIFOs.
        @(negedge clk);
        check("rst_tx", 32'(tx_v), 32'h7);
        check("rst_busy", 32'(busy_v), 32'h0);
        check("rst_rd_en", 32'(rd_v), 32'h0);
        check("rst_done", 32'(fd_v), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Empty FIFO for 100 cycles: nothing moves.
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check("idle_tx", 32'(tx_v[0]), 32'd1);
            check("idle_busy", 32'(busy_v[0]), 32'd0);
            check("idle_rd_en", 32'(rd_v[0]), 32'd0);
        end

        // Single word A5: line 0,1,0,1,0,0,1,0,1,1 at 4 clocks per bit.
        push(0, 8'hA5);
        start_frame(0);
        check_frame(0, 8'hA5, 4, 0, 1, 1'b0, -1);

        // Back-to-back 01 (parity 1) then FF (parity 0) with no busy gap.
        @(negedge clk);
        push(1, 8'h01);
        push(1, 8'hFF);
        start_frame(1);
        check_frame(1, 8'h01, 4, 1, 1, 1'b1, -1);
        check_frame(1, 8'hFF, 4, 1, 1, 1'b0, -1);

        // Two stop bits at 2 clocks per bit: 4 high cycles before frame_done.
        @(negedge clk);
        push(2, 8'h5A);
        start_frame(2);
        check_frame(2, 8'h5A, 2, 0, 2, 1'b0, -1);

        // tx_en dropped mid-DATA with three words queued.
        @(negedge clk);
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        start_frame(0);
        check_frame(0, 8'h11, 4, 0, 1, 1'b0, 20);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("halt_rd_en", 32'(rd_v[0]), 32'd0);
            check("halt_busy", 32'(busy_v[0]), 32'd0);
        end

        // Reset in the middle of DATA: 22 is lost, 33 goes out as a fresh frame.
        tx_en_v[0] = 1'b1;
        start_frame(0);
        repeat (16) @(negedge clk);
        check("pre_rst_busy", 32'(busy_v[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx_v[0]), 32'd1);
        check("mid_rst_busy", 32'(busy_v[0]), 32'd0);
        check("mid_rst_rd_en", 32'(rd_v[0]), 32'd0);
        @(negedge clk);
        check("held_rst_tx", 32'(tx_v[0]), 32'd1);
        rst_n = 1'b1;
        start_frame(0);
        check_frame(0, 8'h33, 4, 0, 1, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
